pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates memory stalls, branch/jump redirects
// and load-use interlocks. Keeps saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             redirect_pulse,
    input  logic [31:0]      redirect_target,
    output logic             pc_stall,
    output logic             IF_ID_stall,
    output logic             ID_EX_bubble,
    output logic             pipe_freeze,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pc_redirect_valid,
    output logic [31:0]      pc_redirect_target,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StStall   = 2'd1;
    localparam logic [1:0] StStallRd = 2'd2;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic        mem_stall;
    logic        load_use;
    logic        apply;
    logic [31:0] apply_tgt;
    logic        load_use_act;

    assign mem_stall = icache_stall | dcache_stall;
    assign load_use  = ID_EX_MemRead & (ID_EX_RegisterRd != 5'd0) &
                       ((IF_ID_use_rs1 & (ID_EX_RegisterRd == IF_ID_RegisterRs1)) |
                        (IF_ID_use_rs2 & (ID_EX_RegisterRd == IF_ID_RegisterRs2)));

    // Redirect application decision; a pulse on the STALL_RD exit cycle is the youngest.
    always_comb begin
        apply     = 1'b0;
        apply_tgt = 32'd0;
        case (state_q)
            StRun, StStall: begin
                if (!mem_stall && redirect_pulse) begin
                    apply     = 1'b1;
                    apply_tgt = redirect_target;
                end
            end
            StStallRd: begin
                if (!mem_stall) begin
                    apply     = 1'b1;
                    apply_tgt = redirect_pulse ? redirect_target : pend_q;
                end
            end
            default: begin
                apply     = 1'b0;
                apply_tgt = 32'd0;
            end
        endcase
    end

    assign load_use_act = load_use & ~mem_stall & ~apply;

    // Next state and pending-target capture; any pulse during a memory stall is parked.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (mem_stall) begin
            if (redirect_pulse) begin
                state_d = StStallRd;
                pend_d  = redirect_target;
            end else if (state_q != StStallRd) begin
                state_d = StStall;
            end
        end else begin
            state_d = StRun;
            if (state_q == StStallRd) begin
                pend_d = 32'd0;
            end
        end
    end

    // Control outputs, all forced low while reset is asserted.
    always_comb begin
        pc_stall           = 1'b0;
        IF_ID_stall        = 1'b0;
        ID_EX_bubble       = 1'b0;
        pipe_freeze        = 1'b0;
        IF_ID_flush        = 1'b0;
        ID_EX_flush        = 1'b0;
        pc_redirect_valid  = 1'b0;
        pc_redirect_target = 32'd0;
        if (!rst) begin
            if (mem_stall) begin
                pc_stall    = 1'b1;
                IF_ID_stall = 1'b1;
                pipe_freeze = 1'b1;
            end else if (apply) begin
                pc_redirect_valid  = 1'b1;
                pc_redirect_target = apply_tgt;
                IF_ID_flush        = 1'b1;
                ID_EX_flush        = 1'b1;
            end else if (load_use_act) begin
                pc_stall     = 1'b1;
                IF_ID_stall  = 1'b1;
                ID_EX_bubble = 1'b1;
            end
        end
    end

    // FSM state and pending redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (pc_redirect_valid && (flush_cnt_q != CntMax)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl. A second instance with
// CNT_W=4 shares the same stimulus and is used for counter saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_RegisterRd;
    logic [4:0]  IF_ID_RegisterRs1;
    logic [4:0]  IF_ID_RegisterRs2;
    logic        IF_ID_use_rs1;
    logic        IF_ID_use_rs2;
    logic        icache_stall;
    logic        dcache_stall;
    logic        redirect_pulse;
    logic [31:0] redirect_target;

    logic        pc_stall, IF_ID_stall, ID_EX_bubble, pipe_freeze;
    logic        IF_ID_flush, ID_EX_flush, pc_redirect_valid;
    logic [31:0] pc_redirect_target;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_stall, s_IF_ID_stall, s_ID_EX_bubble, s_pipe_freeze;
    logic        s_IF_ID_flush, s_ID_EX_flush, s_pc_redirect_valid;
    logic [31:0] s_pc_redirect_target;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipeline_hazard_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .ID_EX_MemRead      (ID_EX_MemRead),
        .ID_EX_RegisterRd   (ID_EX_RegisterRd),
        .IF_ID_RegisterRs1  (IF_ID_RegisterRs1),
        .IF_ID_RegisterRs2  (IF_ID_RegisterRs2),
        .IF_ID_use_rs1      (IF_ID_use_rs1),
        .IF_ID_use_rs2      (IF_ID_use_rs2),
        .icache_stall       (icache_stall),
        .dcache_stall       (dcache_stall),
        .redirect_pulse     (redirect_pulse),
        .redirect_target    (redirect_target),
        .pc_stall           (pc_stall),
        .IF_ID_stall        (IF_ID_stall),
        .ID_EX_bubble       (ID_EX_bubble),
        .pipe_freeze        (pipe_freeze),
        .IF_ID_flush        (IF_ID_flush),
        .ID_EX_flush        (ID_EX_flush),
        .pc_redirect_valid  (pc_redirect_valid),
        .pc_redirect_target (pc_redirect_target),
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk                (clk),
        .rst                (rst),
        .ID_EX_MemRead      (ID_EX_MemRead),
        .ID_EX_RegisterRd   (ID_EX_RegisterRd),
        .IF_ID_RegisterRs1  (IF_ID_RegisterRs1),
        .IF_ID_RegisterRs2  (IF_ID_RegisterRs2),
        .IF_ID_use_rs1      (IF_ID_use_rs1),
        .IF_ID_use_rs2      (IF_ID_use_rs2),
        .icache_stall       (icache_stall),
        .dcache_stall       (dcache_stall),
        .redirect_pulse     (redirect_pulse),
        .redirect_target    (redirect_target),
        .pc_stall           (s_pc_stall),
        .IF_ID_stall        (s_IF_ID_stall),
        .ID_EX_bubble       (s_ID_EX_bubble),
        .pipe_freeze        (s_pipe_freeze),
        .IF_ID_flush        (s_IF_ID_flush),
        .ID_EX_flush        (s_ID_EX_flush),
        .pc_redirect_valid  (s_pc_redirect_valid),
        .pc_redirect_target (s_pc_redirect_target),
        .stall_cnt          (s_stall_cnt),
        .flush_cnt          (s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_EX_MemRead     = 1'b0;
        ID_EX_RegisterRd  = 5'd0;
        IF_ID_RegisterRs1 = 5'd0;
        IF_ID_RegisterRs2 = 5'd0;
        IF_ID_use_rs1     = 1'b0;
        IF_ID_use_rs2     = 1'b0;
        icache_stall      = 1'b0;
        dcache_stall      = 1'b0;
        redirect_pulse    = 1'b0;
        redirect_target   = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        icache_stall   = 1'b1;
        redirect_pulse = 1'b1;
        redirect_target = 32'h0000_0040;
        next_cycle();
        next_cycle();
        #1;
        n_checks++;
        if ({pc_stall, IF_ID_stall, pipe_freeze, pc_redirect_valid, IF_ID_flush} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {pc_stall, IF_ID_stall, pipe_freeze, pc_redirect_valid, IF_ID_flush});
        end
        n_checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
        end
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (pc_stall !== 1'b0 || pc_redirect_valid !== 1'b0 || pc_redirect_target !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release: got stall=%b valid=%b tgt=%h required 0 0 0",
                     pc_stall, pc_redirect_valid, pc_redirect_target);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        ID_EX_MemRead     = 1'b1;
        ID_EX_RegisterRd  = 5'd5;
        IF_ID_RegisterRs1 = 5'd5;
        IF_ID_use_rs1     = 1'b1;
        #1;
        n_checks++;
        if ({pc_stall, IF_ID_stall, ID_EX_bubble, pipe_freeze} !== 4'b1110) begin
            n_fail++;
            $display("FAIL load_use_rs1: got %b required 1110",
                     {pc_stall, IF_ID_stall, ID_EX_bubble, pipe_freeze});
        end
        exp_stall++;
        next_cycle();
        idle_inputs();
        ID_EX_MemRead     = 1'b1;
        ID_EX_RegisterRd  = 5'd7;
        IF_ID_RegisterRs1 = 5'd3;
        IF_ID_RegisterRs2 = 5'd7;
        IF_ID_use_rs2     = 1'b1;
        #1;
        n_checks++;
        if ({pc_stall, ID_EX_bubble} !== 2'b11) begin
            n_fail++;
            $display("FAIL load_use_rs2: got %b required 11", {pc_stall, ID_EX_bubble});
        end
        exp_stall++;
        next_cycle();
        IF_ID_use_rs2 = 1'b0;
        #1;
        n_checks++;
        if (pc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_unused_src: got %b required 0", pc_stall);
        end
        n_checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_fail++;
            $display("FAIL load_use_cnt: got %0d required %0d", stall_cnt, exp_stall);
        end
        idle_inputs();
    endtask

    task automatic test_rd_zero();
        next_cycle();
        ID_EX_MemRead     = 1'b1;
        ID_EX_RegisterRd  = 5'd0;
        IF_ID_RegisterRs1 = 5'd0;
        IF_ID_use_rs1     = 1'b1;
        #1;
        n_checks++;
        if ({pc_stall, ID_EX_bubble} !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_zero: got %b required 00", {pc_stall, ID_EX_bubble});
        end
        next_cycle();
        idle_inputs();
        ID_EX_RegisterRd  = 5'd5;
        IF_ID_RegisterRs1 = 5'd5;
        IF_ID_use_rs1     = 1'b1;
        #1;
        n_checks++;
        if (pc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL no_memread: got %b required 0", pc_stall);
        end
        idle_inputs();
    endtask

    task automatic test_redirect_run();
        next_cycle();
        redirect_pulse    = 1'b1;
        redirect_target   = 32'h0000_0040;
        ID_EX_MemRead     = 1'b1;
        ID_EX_RegisterRd  = 5'd9;
        IF_ID_RegisterRs1 = 5'd9;
        IF_ID_use_rs1     = 1'b1;
        #1;
        n_checks++;
        if ({pc_redirect_valid, IF_ID_flush, ID_EX_flush, pc_stall, ID_EX_bubble} !== 5'b11100
            || pc_redirect_target !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL redirect_run: got %b tgt=%h required 11100 tgt=00000040",
                     {pc_redirect_valid, IF_ID_flush, ID_EX_flush, pc_stall, ID_EX_bubble},
                     pc_redirect_target);
        end
        exp_flush++;
        next_cycle();
        idle_inputs();
        redirect_target = 32'hdead_beef;
        #1;
        n_checks++;
        if (pc_redirect_valid !== 1'b0 || pc_redirect_target !== 32'd0 || flush_cnt !== 16'(exp_flush)) begin
            n_fail++;
            $display("FAIL redirect_run_after: got valid=%b tgt=%h fcnt=%0d required 0 0 %0d",
                     pc_redirect_valid, pc_redirect_target, flush_cnt, exp_flush);
        end
        idle_inputs();
    endtask

    task automatic test_dcache_redirect();
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            idle_inputs();
            dcache_stall = 1'b1;
            if (c == 1) begin
                redirect_pulse  = 1'b1;
                redirect_target = 32'h0000_0100;
            end
            #1;
            n_checks++;
            if ({pc_stall, IF_ID_stall, pipe_freeze, pc_redirect_valid, IF_ID_flush, ID_EX_flush}
                !== 6'b111000) begin
                n_fail++;
                $display("FAIL dstall_cycle%0d: got %b required 111000", c,
                         {pc_stall, IF_ID_stall, pipe_freeze, pc_redirect_valid, IF_ID_flush,
                          ID_EX_flush});
            end
            exp_stall++;
        end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 32'h0000_0100 ||
            IF_ID_flush !== 1'b1 || pc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL dstall_apply: got valid=%b tgt=%h flush=%b stall=%b required 1 100 1 0",
                     pc_redirect_valid, pc_redirect_target, IF_ID_flush, pc_stall);
        end
        exp_flush++;
        next_cycle();
        #1;
        n_checks++;
        if (pc_redirect_valid !== 1'b0 || flush_cnt !== 16'(exp_flush) ||
            stall_cnt !== 16'(exp_stall)) begin
            n_fail++;
            $display("FAIL dstall_after: got valid=%b fcnt=%0d scnt=%0d required 0 %0d %0d",
                     pc_redirect_valid, flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
    endtask

    task automatic test_double_redirect();
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            idle_inputs();
            dcache_stall = 1'b1;
            if (c == 1) begin
                redirect_pulse  = 1'b1;
                redirect_target = 32'h0000_0100;
            end else if (c == 2) begin
                redirect_pulse  = 1'b1;
                redirect_target = 32'h0000_0200;
            end
            exp_stall++;
        end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL double_redirect: got valid=%b tgt=%h required 1 00000200",
                     pc_redirect_valid, pc_redirect_target);
        end
        exp_flush++;
        next_cycle();
        #1;
        n_checks++;
        if (pc_redirect_valid !== 1'b0 || flush_cnt !== 16'(exp_flush)) begin
            n_fail++;
            $display("FAIL double_redirect_once: got valid=%b fcnt=%0d required 0 %0d",
                     pc_redirect_valid, flush_cnt, exp_flush);
        end
    endtask

    task automatic test_stall_then_pulse();
        next_cycle();
        icache_stall = 1'b1;
        exp_stall++;
        next_cycle();
        idle_inputs();
        redirect_pulse  = 1'b1;
        redirect_target = 32'h0000_0300;
        #1;
        n_checks++;
        if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 32'h0000_0300 || pc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_exit_pulse: got valid=%b tgt=%h stall=%b required 1 00000300 0",
                     pc_redirect_valid, pc_redirect_target, pc_stall);
        end
        exp_flush++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        next_cycle();
        dcache_stall    = 1'b1;
        redirect_pulse  = 1'b1;
        redirect_target = 32'h0000_0400;
        next_cycle();
        redirect_pulse = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || pc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got scnt=%0d fcnt=%0d stall=%b required 0 0 0",
                     stall_cnt, flush_cnt, pc_stall);
        end
        exp_stall = 0;
        exp_flush = 0;
        next_cycle();
        idle_inputs();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (pc_redirect_valid !== 1'b0 || IF_ID_flush !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_discard%0d: got valid=%b flush=%b required 0 0", c,
                         pc_redirect_valid, IF_ID_flush);
            end
            next_cycle();
        end
        n_checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_discard_cnt: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            icache_stall = 1'b1;
            exp_stall++;
        end
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (s_stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate_w4: got %0d required 15", s_stall_cnt);
        end
        n_checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_fail++;
            $display("FAIL stall_cnt_w16: got %0d required %0d", stall_cnt, exp_stall);
        end
        next_cycle();
        icache_stall = 1'b1;
        next_cycle();
        idle_inputs();
        #1;
        n_checks++;
        if (s_stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate_hold: got %0d required 15", s_stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_redirect_run();
        test_dcache_redirect();
        test_double_redirect();
        test_stall_then_pulse();
        test_reset_mid_stall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
